// File: rtl/mac_pipe_acc.sv
// Pipelined signed multiply-accumulate with single-MAC and frame-accumulate modes.
// Optional build macro MAC_SAT_EN: clamp result on overflow instead of wrapping.
module mac_pipe_acc #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int C_W   = 16,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    mode,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   a_in,
  input  logic signed [B_W-1:0]   b_in,
  input  logic signed [C_W-1:0]   c_in,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] result,
  output logic                    overflow
);

  localparam int P_W = A_W + B_W;

  generate
    if (ACC_W < P_W + 1 || ACC_W < C_W + 1 || OUT_W > ACC_W) begin : g_bad_widths
      $error("mac_pipe_acc: ACC_W must be >= A_W+B_W+1 and >= C_W+1, and OUT_W <= ACC_W");
    end
  endgenerate

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  // Stage 1: operand capture
  logic                  s1_valid_reg, s1_mode_reg, s1_first_reg, s1_last_reg;
  logic signed [A_W-1:0] s1_a_reg;
  logic signed [B_W-1:0] s1_b_reg;
  logic signed [C_W-1:0] s1_c_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_c_reg     <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_mode_reg  <= mode;
        s1_first_reg <= in_first;
        s1_last_reg  <= in_last;
        s1_a_reg     <= a_in;
        s1_b_reg     <= b_in;
        s1_c_reg     <= c_in;
      end
    end
  end

  // Stage 2: full-width signed product
  logic                  s2_valid_reg, s2_mode_reg, s2_first_reg, s2_last_reg;
  logic signed [P_W-1:0] s2_prod_reg;
  logic signed [C_W-1:0] s2_c_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_mode_reg  <= 1'b0;
      s2_first_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_prod_reg  <= '0;
      s2_c_reg     <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_mode_reg  <= s1_mode_reg;
        s2_first_reg <= s1_first_reg;
        s2_last_reg  <= s1_last_reg;
        s2_prod_reg  <= s1_a_reg * s1_b_reg;
        s2_c_reg     <= s1_c_reg;
      end
    end
  end

  // Stage 3: frame FSM and accumulator
  logic signed [ACC_W-1:0] prod_ext, c_ext;
  logic signed [ACC_W-1:0] acc_reg, acc_next, sum_next, s3_sum_reg;
  logic                    emit_next, s3_valid_reg;
  state_t                  state_reg, state_next;

  assign prod_ext = {{(ACC_W-P_W){s2_prod_reg[P_W-1]}}, s2_prod_reg};
  assign c_ext    = {{(ACC_W-C_W){s2_c_reg[C_W-1]}}, s2_c_reg};

  always_comb begin
    sum_next   = acc_reg;
    acc_next   = acc_reg;
    emit_next  = 1'b0;
    state_next = state_reg;
    if (s2_valid_reg) begin
      if (!s2_mode_reg) begin
        // Single MAC; any open frame is dropped.
        sum_next   = prod_ext + c_ext;
        acc_next   = '0;
        emit_next  = 1'b1;
        state_next = IDLE;
      end else begin
        if (state_reg == IDLE || s2_first_reg) sum_next = c_ext + prod_ext;
        else                                   sum_next = acc_reg + prod_ext;
        acc_next = sum_next;
        if (s2_last_reg) begin
          emit_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      s3_valid_reg <= 1'b0;
      s3_sum_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      s3_valid_reg <= emit_next;
      if (emit_next) s3_sum_reg <= sum_next;
    end
  end

  // Output stage: range check and wrap/clamp, held between pulses
  logic                    ovf_next;
  logic signed [OUT_W-1:0] result_next;

  assign ovf_next = (s3_sum_reg > OUT_MAX) || (s3_sum_reg < OUT_MIN);

`ifdef MAC_SAT_EN
  assign result_next = !ovf_next ? s3_sum_reg[OUT_W-1:0]
                     : (s3_sum_reg[ACC_W-1] ? OUT_MIN[OUT_W-1:0] : OUT_MAX[OUT_W-1:0]);
`else
  assign result_next = s3_sum_reg[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= s3_valid_reg;
      if (s3_valid_reg) begin
        result   <= result_next;
        overflow <= ovf_next;
      end
    end
  end

endmodule

// File: doc/mac_pipe_acc.md
Name: mac_pipe_acc

Overview:
Parameterised, fully pipelined signed multiply-accumulate engine. It is the successor to the fixed 16x16+16 MAC wrapper. It adds configurable operand and accumulator widths, a valid-qualified stream interface, and a frame-accumulate mode for dot products and FIR taps. It sits between sample/coefficient sources and downstream filter or output logic. No backpressure: one sample per cycle, always accepted.

Parameters:
A_W, 16, signed width of a_in
B_W, 16, signed width of b_in
C_W, 16, signed width of c_in (addend / frame bias)
ACC_W, 40, internal accumulator width; must be >= A_W+B_W+1 and >= C_W+1 (elaboration-time check, $error if violated)
OUT_W, 32, signed width of result; must be <= ACC_W

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  qualifies a_in/b_in/c_in/mode/in_first/in_last
mode  in  1  0 = single MAC (a*b+c); 1 = frame accumulate
in_first  in  1  mode 1: first sample of a frame; c_in used as bias
in_last  in  1  mode 1: last sample of a frame; triggers output
a_in  in  A_W  signed multiplicand
b_in  in  B_W  signed multiplier
c_in  in  C_W  signed addend; ignored in mode 1 unless in_first
out_valid  out  1  one-cycle pulse, result/overflow valid
result  out  OUT_W  signed result
overflow  out  1  final accumulator value not representable in OUT_W; valid with out_valid

Behaviour:
- Reset: out_valid=0, result=0, overflow=0, accumulator=0, all pipeline valid bits=0, FSM=IDLE. Takes effect on the clock edge with reset high. Reset mid-frame discards the partial sum and produces no out_valid.
- Pipeline:
  - S1: register operands and flags when in_valid.
  - S2: signed product, A_W+B_W bits.
  - S3: accumulate/add, then output registers.
- Latency: exactly 3 cycles, from in_valid sampled at edge N to out_valid high after edge N+3.
- Throughput: 1 sample/cycle. in_valid=0 inserts bubbles; bubbles never alter the accumulator.
- All arithmetic is two's complement. Operands sign-extend to ACC_W. The accumulator wraps modulo 2^ACC_W; sizing ACC_W is the integrator's job.
- Frame FSM (advances in S3), states IDLE and ACCUM:
  - mode 0 sample (either state): output = sext(a*b)+sext(c); out_valid=1; FSM -> IDLE. An open frame is aborted and its partial sum discarded.
  - mode 1, IDLE, or any in_first: acc = sext(c)+sext(a*b). If in_last, output and stay IDLE; else -> ACCUM. A first sample without in_first in IDLE is treated as in_first.
  - mode 1, ACCUM, not in_first: acc += sext(a*b); c ignored. If in_last, output and go -> IDLE.
  - in_first and in_last in the same sample: single-term frame, result = a*b+c.
- Output:
  - overflow = 1 when the final value is > 2^(OUT_W-1)-1 or < -2^(OUT_W-1).
  - result takes the low OUT_W bits (wrap), unless the optional feature is enabled.
  - result and overflow hold their values between out_valid pulses.

Optional Feature:
MAC_SAT_EN:
- Defined: on overflow, result clamps to 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative).
- Undefined: result wraps (low OUT_W bits).
- overflow is reported identically in both builds.
- Accumulator behaviour and latency are unchanged.

Test Plan:
1. Defaults. mode 0, back-to-back cycles (-5,3,10), (7,2,5), (-32768,2,0) -> out_valid on three consecutive cycles starting 3 cycles after the first input; result -5, 19, -65536; overflow 0.
2. mode 1, 4-sample frame:
   - a = 100, -200, 300, 1000; b = 2, 3, -1, 1000; c = 10 on in_first.
   - Required: single out_valid 3 cycles after in_last; result 999310; no out_valid on intermediate samples.
3. mode 1, in_first and in_last together with (-4,-3,2) -> result 14. Repeat with in_valid gaps of 1-3 cycles inside the test-2 frame -> identical 999310.
4. Overflow, frame of three samples (32767,32767), c=0:
   - Required: sum 3221028867, overflow=1.
   - Without MAC_SAT_EN: result -1073938429.
   - With MAC_SAT_EN: result 2147483647.
5. Reset and mode abort:
   - Reset: two mode 1 samples, reset high 1 cycle, then mode 1 first+last (6,-2,8) -> no spurious out_valid; result -4.
   - Abort: a mode 0 sample (3,3,1) mid-frame -> result 10; the aborted frame never outputs.
